// File: rtl/data_channel.sv
// Two-stage SECDED link: stage 1 encodes data_in into the channel register,
// stage 2 decodes it, correcting single errors and flagging double errors.
module data_channel (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       error_detected,
    output logic       error_corrected
);

    localparam int unsigned DW = 8;
    localparam int unsigned CW = 13;
    localparam int unsigned SW = 4;

    // Channel register; kept under this name so errors can be forced onto it.
    logic [CW-1:0] received_data;

    logic [DW-1:0] data_out_q, data_out_d;
    logic          det_q, det_d;
    logic          cor_q, cor_d;

    logic [CW-1:0] enc_d;
    logic [SW-1:0] syn;
    logic          par;
    logic [DW-1:0] raw_data;
    logic [DW-1:0] data_flip;

    // Hamming(12,8) with parity at 1,2,4,8 plus overall even parity in bit 0
    always_comb begin
        enc_d     = '0;
        enc_d[3]  = data_in[0];
        enc_d[5]  = data_in[1];
        enc_d[6]  = data_in[2];
        enc_d[7]  = data_in[3];
        enc_d[9]  = data_in[4];
        enc_d[10] = data_in[5];
        enc_d[11] = data_in[6];
        enc_d[12] = data_in[7];
        enc_d[1]  = data_in[0] ^ data_in[1] ^ data_in[3] ^ data_in[4] ^ data_in[6];
        enc_d[2]  = data_in[0] ^ data_in[2] ^ data_in[3] ^ data_in[5] ^ data_in[6];
        enc_d[4]  = data_in[1] ^ data_in[2] ^ data_in[3] ^ data_in[7];
        enc_d[8]  = data_in[4] ^ data_in[5] ^ data_in[6] ^ data_in[7];
        enc_d[0]  = ^enc_d[12:1];
    end

    // Syndrome includes the stored parity bit, so zero means consistent
    always_comb begin
        syn[0] = received_data[1] ^ received_data[3] ^ received_data[5]
               ^ received_data[7] ^ received_data[9] ^ received_data[11];
        syn[1] = received_data[2] ^ received_data[3] ^ received_data[6]
               ^ received_data[7] ^ received_data[10] ^ received_data[11];
        syn[2] = received_data[4] ^ received_data[5] ^ received_data[6]
               ^ received_data[7] ^ received_data[12];
        syn[3] = received_data[8] ^ received_data[9] ^ received_data[10]
               ^ received_data[11] ^ received_data[12];
        par    = ^received_data;
        raw_data = {received_data[12], received_data[11], received_data[10],
                    received_data[9], received_data[7], received_data[6],
                    received_data[5], received_data[3]};
    end

    // Only data positions matter for the corrected word; parity-bit fixes leave data alone
    always_comb begin
        data_flip[0] = (syn == SW'(3));
        data_flip[1] = (syn == SW'(5));
        data_flip[2] = (syn == SW'(6));
        data_flip[3] = (syn == SW'(7));
        data_flip[4] = (syn == SW'(9));
        data_flip[5] = (syn == SW'(10));
        data_flip[6] = (syn == SW'(11));
        data_flip[7] = (syn == SW'(12));
    end

    always_comb begin
        data_out_d = raw_data;
        det_d      = 1'b0;
        cor_d      = 1'b0;
        if (par) begin
            det_d = 1'b1;
            if (syn <= SW'(12)) begin
                cor_d      = 1'b1;
                data_out_d = raw_data ^ data_flip;
            end
        end else if (syn != '0) begin
            det_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            received_data <= '0;
            data_out_q    <= '0;
            det_q         <= 1'b0;
            cor_q         <= 1'b0;
        end else begin
            received_data <= enc_d;
            data_out_q    <= data_out_d;
            det_q         <= det_d;
            cor_q         <= cor_d;
        end
    end

    assign data_out        = data_out_q;
    assign error_detected  = det_q;
    assign error_corrected = cor_q;

endmodule

// File: tb/tb_data_channel.sv
// Bench for data_channel: scoreboard-checked streaming, table-driven error
// injection through the channel register, and asynchronous reset sequences.
module tb_data_channel;

    logic       clk;
    logic       rst;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       error_detected;
    logic       error_corrected;

    data_channel dut (
        .clk             (clk),
        .rst             (rst),
        .data_in         (data_in),
        .data_out        (data_out),
        .error_detected  (error_detected),
        .error_corrected (error_corrected)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        logic       det;
        logic       cor;
        int         due;
    } exp_t;

    typedef struct {
        logic [7:0]  din;
        logic [12:0] mask;
        logic [7:0]  exp_out;
        logic        exp_det;
        logic        exp_cor;
    } vec_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [12:0] inj;

    function automatic logic [12:0] enc(input logic [7:0] d);
        logic [12:0] c;
        c = '0;
        c[3] = d[0]; c[5] = d[1]; c[6] = d[2]; c[7] = d[3];
        c[9] = d[4]; c[10] = d[5]; c[11] = d[6]; c[12] = d[7];
        c[1] = c[3] ^ c[5] ^ c[7] ^ c[9] ^ c[11];
        c[2] = c[3] ^ c[6] ^ c[7] ^ c[10] ^ c[11];
        c[4] = c[5] ^ c[6] ^ c[7] ^ c[12];
        c[8] = c[9] ^ c[10] ^ c[11] ^ c[12];
        c[0] = ^c[12:1];
        return c;
    endfunction

    task automatic check_out(input string name, input logic [7:0] d,
                             input logic det, input logic cor);
        checks++;
        if (data_out !== d || error_detected !== det || error_corrected !== cor) begin
            errors++;
            $display("FAIL %s cyc=%0d got out=%02h det=%b cor=%b want out=%02h det=%b cor=%b",
                     name, cyc, data_out, error_detected, error_corrected, d, det, cor);
        end
    endtask

    // Advance one edge and retire every scoreboard entry due on it
    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            if (e.due != cyc) begin
                checks++;
                errors++;
                $display("FAIL sb_late cyc=%0d got due=%0d want due=%0d", cyc, e.due, cyc);
            end else begin
                check_out("sb", e.d, e.det, e.cor);
            end
        end
    endtask

    task automatic push(input logic [7:0] d, input logic det, input logic cor, input int lat);
        exp_t e;
        e.d = d; e.det = det; e.cor = cor; e.due = cyc + lat;
        sb.push_back(e);
    endtask

    // Load din, corrupt the channel register with mask, check the decode
    task automatic inject(input vec_t v);
        data_in = v.din;
        tick();
        inj = enc(v.din) ^ v.mask;
        force dut.received_data = inj;
        push(v.exp_out, v.exp_det, v.exp_cor, 1);
        tick();
        release dut.received_data;
        data_in = 8'h00;
        tick();
        tick();
    endtask

    vec_t vecs[10];

    initial begin
        vecs[0] = '{din: 8'hF0, mask: 13'h0001, exp_out: 8'hF0, exp_det: 1'b1, exp_cor: 1'b1};
        vecs[1] = '{din: 8'h55, mask: 13'h0008, exp_out: 8'h55, exp_det: 1'b1, exp_cor: 1'b1};
        vecs[2] = '{din: 8'h0F, mask: 13'h000A, exp_out: 8'h0E, exp_det: 1'b1, exp_cor: 1'b0};
        vecs[3] = '{din: 8'h3C, mask: 13'h0000, exp_out: 8'h3C, exp_det: 1'b0, exp_cor: 1'b0};
        vecs[4] = '{din: 8'hA5, mask: 13'h1000, exp_out: 8'hA5, exp_det: 1'b1, exp_cor: 1'b1};
        vecs[5] = '{din: 8'h81, mask: 13'h0100, exp_out: 8'h81, exp_det: 1'b1, exp_cor: 1'b1};
        vecs[6] = '{din: 8'h12, mask: 13'h0112, exp_out: 8'h12, exp_det: 1'b1, exp_cor: 1'b0};
        vecs[7] = '{din: 8'hFF, mask: 13'h1800, exp_out: 8'h3F, exp_det: 1'b1, exp_cor: 1'b0};
        vecs[8] = '{din: 8'h00, mask: 13'h0080, exp_out: 8'h00, exp_det: 1'b1, exp_cor: 1'b1};
        vecs[9] = '{din: 8'h69, mask: 13'h0000, exp_out: 8'h69, exp_det: 1'b0, exp_cor: 1'b0};

        rst = 1'b0;
        data_in = 8'h00;
        inj = '0;
        tick();
        check_out("reset", 8'h00, 1'b0, 1'b0);
        #3 rst = 1'b1;

        // Clean stream, two-edge latency
        data_in = 8'hAA; push(8'hAA, 1'b0, 1'b0, 2); tick();
        data_in = 8'hCC; push(8'hCC, 1'b0, 1'b0, 2); tick();
        for (int i = 0; i < 16; i++) begin
            data_in = 8'($urandom_range(0, 255));
            push(data_in, 1'b0, 1'b0, 2);
            tick();
        end
        data_in = 8'h00;
        tick();
        tick();

        for (int i = 0; i < 10; i++) inject(vecs[i]);

        // Recovery stream after forced errors
        data_in = 8'h3C; push(8'h3C, 1'b0, 1'b0, 2); tick();
        data_in = 8'hC3; push(8'hC3, 1'b0, 1'b0, 2); tick();
        tick();
        tick();

        // Asynchronous reset mid-stream
        for (int i = 0; i < 4; i++) begin
            data_in = 8'hFF; push(8'hFF, 1'b0, 1'b0, 2); tick();
        end
        #3 rst = 1'b0;
        #1;
        sb.delete();
        check_out("async_rst", 8'h00, 1'b0, 1'b0);
        checks++;
        if (dut.received_data !== 13'h0) begin
            errors++;
            $display("FAIL async_rst_chan got %h want 0000", dut.received_data);
        end
        tick();
        check_out("rst_hold", 8'h00, 1'b0, 1'b0);
        #3 rst = 1'b1;
        data_in = 8'h5A;
        push(8'h00, 1'b0, 1'b0, 1);
        push(8'h5A, 1'b0, 1'b0, 2);
        tick();
        data_in = 8'h6B; push(8'h6B, 1'b0, 1'b0, 2); tick();
        data_in = 8'h00;
        tick();
        tick();

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain got %0d pending want 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
